div_sched: RTL
==============

# div_sched

Controller that sequences the shared multi-cycle unsigned divider core for DIV/MOD/DIVU/MODU in the execute stage. It accepts one operation at a time over a valid/ready handshake and converts signed operands to magnitudes for the core. It applies sign correction, short-circuits divide-by-zero, and serves a repeated DIV/MOD pair on identical operands from a one-entry result cache. It holds the result until the pipeline accepts it and aborts cleanly on pipeline flush.

## Interface
- WIDTH, 32, operand/result width
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  operation request
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  2  00 DIV, 01 MOD, 10 DIVU, 11 MODU
- req_src1  in  WIDTH  dividend
- req_src2  in  WIDTH  divisor
- flush  in  1  pipeline flush; abort any operation
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed when high with resp_valid
- resp_data  out  WIDTH  quotient or remainder per op
- busy  out  1  high in any state other than IDLE
- core_start  out  1  one-cycle start pulse to divider core
- core_flush  out  1  one-cycle abort pulse to divider core
- core_dividend  out  WIDTH  unsigned dividend magnitude, valid with core_start
- core_divisor  out  WIDTH  unsigned divisor magnitude, valid with core_start
- core_done  in  1  one-cycle pulse, core result valid
- core_quotient  in  WIDTH  unsigned quotient
- core_remainder  in  WIDTH  unsigned remainder

## Operation
- States: IDLE, START, BUSY, DONE.
- req_ready = (state==IDLE) && !flush.
- On accept, register op, operands and signedness (signed = !op[1]).
- Cache: last_valid, last_src1, last_src2, last_signed, last_q, last_r.
- Hit: last_valid && src1/src2/signed all equal. On a hit, go to DONE and select last_q or last_r by op[0]. No core_start.
- Divisor zero (no hit): go to DONE with q = all-ones and r = dividend. No core_start. The cache is not written.
- Otherwise go to START:
  - Pulse core_start.
  - core_dividend = signed && src1[MSB] ? -src1 : src1; same rule for the divisor.
  - Then go to BUSY.
- BUSY, on core_done:
  - Quotient is negated iff signed && (src1[MSB]^src2[MSB]).
  - Remainder is negated iff signed && src1[MSB].
  - Write q/r into the cache with last_valid=1, latch resp_data, go to DONE.
- 0x80000000 / 0xFFFFFFFF signed needs no special case. The core yields 0x80000000/1; after negation q=0x80000000, r=0.
- DONE: resp_valid=1 and resp_data stable. On resp_ready, go to IDLE.
- Flush, from any state:
  - Next state is IDLE and resp_valid drops next cycle.
  - If the state is START or BUSY, pulse core_flush the same cycle (combinational) and do not issue core_start.
  - Cache is not written; a previously valid entry is retained.
- Priority: flush > core_done > resp handshake.
- core_done in states other than BUSY is ignored.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_data 0, core_start 0, core_flush 0, busy 0, last_valid 0, all cache fields 0. req_ready=1 after reset release.
- Accept at cycle T.
- Hit or zero-divisor: resp_valid at T+1, so latency is 1.
- Miss:
  - core_start at T+1.
  - core_done at D ≥ T+2.
  - resp_valid at D+1.
- A new request is accepted no earlier than the cycle after the response handshake. There is no back-to-back overlap.
- Flush at cycle F: busy=0 and req_ready=1 at F+1.
- A core_done arriving in the same cycle as flush is discarded.

## Test plan
- DIV signed 0xFFFFFFF9 / 2 (core returns q=3, r=1) -> resp_data 0xFFFFFFFD one cycle after core_done. One core_start with dividend 7, divisor 2.
- MOD with the same operands immediately after -> resp_data 0xFFFFFFFF at T+1. core_start stays low (cache hit).
- DIVU 0xFFFFFFF9 / 2 after the above -> miss on signedness; core_start with dividend 0xFFFFFFF9; resp_data 0x7FFFFFFC.
- DIV 5 / 0 -> resp 0xFFFFFFFF at T+1; MOD 5 / 0 -> resp 5. No core_start in either case.
- Signed 0x80000000 / 0xFFFFFFFF -> core gets 0x80000000/1; DIV resp 0x80000000, MOD resp 0.
- Miss DIV 100/7, flush 2 cycles after core_start -> core_flush pulse, resp_valid never rises. Then a late core_done -> ignored. Next DIV 100/7 -> miss, resp 14.
- resp_ready held low 3 cycles in DONE -> resp_data stable and req_ready low. Handshake on the 4th cycle -> req_ready 1 next cycle.

Source files
------------

// File: rtl/div_sched.sv
// rtl/div_sched.sv - sequencer for the shared multi-cycle unsigned divider (DIV/MOD/DIVU/MODU)
module div_sched #(
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             core_start,
    output logic             core_flush,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             sel_rem;
    logic             signed_q;
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;

    logic             last_valid;
    logic             last_signed;
    logic [WIDTH-1:0] last_src1;
    logic [WIDTH-1:0] last_src2;
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] last_r;

    logic             accept;
    logic             req_signed;
    logic             hit;
    logic             div_zero;
    logic             core_fin;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign req_ready  = (state == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign req_signed = !req_op[1];
    assign hit        = last_valid && (req_src1 == last_src1) && (req_src2 == last_src2)
                        && (req_signed == last_signed);
    assign div_zero   = (req_src2 == '0);

    // A done pulse coinciding with flush belongs to the aborted operation.
    assign core_fin   = (state == BUSY) && core_done && !flush;

    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);
    assign core_start = (state == START) && !flush;
    assign core_flush = ((state == START) || (state == BUSY)) && flush;

    assign core_dividend = (signed_q && src1_q[WIDTH-1]) ? ('0 - src1_q) : src1_q;
    assign core_divisor  = (signed_q && src2_q[WIDTH-1]) ? ('0 - src2_q) : src2_q;

    assign neg_q = signed_q && (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
    assign neg_r = signed_q && src1_q[WIDTH-1];
    assign q_fix = neg_q ? ('0 - core_quotient)  : core_quotient;
    assign r_fix = neg_r ? ('0 - core_remainder) : core_remainder;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (hit || div_zero) ? DONE : START;
                end
            end
            START: state_nxt = BUSY;
            BUSY: begin
                if (core_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sel_rem     <= 1'b0;
            signed_q    <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            resp_data   <= '0;
            last_valid  <= 1'b0;
            last_signed <= 1'b0;
            last_src1   <= '0;
            last_src2   <= '0;
            last_q      <= '0;
            last_r      <= '0;
        end else begin
            if (accept) begin
                sel_rem  <= req_op[0];
                signed_q <= req_signed;
                src1_q   <= req_src1;
                src2_q   <= req_src2;
                if (hit) begin
                    resp_data <= req_op[0] ? last_r : last_q;
                end else if (div_zero) begin
                    resp_data <= req_op[0] ? req_src1 : '1;
                end
            end
            if (core_fin) begin
                resp_data   <= sel_rem ? r_fix : q_fix;
                last_valid  <= 1'b1;
                last_signed <= signed_q;
                last_src1   <= src1_q;
                last_src2   <= src2_q;
                last_q      <= q_fix;
                last_r      <= r_fix;
            end
        end
    end

endmodule
